dram_fft_re: RTL and testbench

- Simple dual-port RAM holding the real part of FFT samples: 256 words x 23 bits.
- Port A is write-only and port B is read-only. Both share one clock.
- Sits between the FFT result writer and the downstream magnitude/readout logic.
- After reset, a built-in clear sweep zeroes the array so reads are deterministic.

---
 rtl/dram_fft_re_pkg.sv | 16 +
 rtl/dram_fft_re_core.sv | 23 ++
 rtl/dram_fft_re.sv | 73 +++++++
 tb/tb_dram_fft_re.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dram_fft_re_pkg.sv
// Shared types and sizes for the FFT real-part sample RAM.
// Imported by the array core and the top-level wrapper.
package dram_fft_re_pkg;

  localparam int DATA_W = 23;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] fft_re_word_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sweep_st_t;

endpackage

// File: rtl/dram_fft_re_core.sv
// Storage array for the FFT real part: one write port, one read port.
// Read-first registered read, no reset, so it maps onto block RAM.
module dram_fft_re_core
  import dram_fft_re_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  fft_re_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dram_fft_re.sv
// FFT real-part sample RAM with a post-reset clear sweep.
// Port A writes, port B reads, both on clka.
module dram_fft_re
  import dram_fft_re_pkg::*;
(
  input  logic              clka,
  input  logic              rst_n,
  input  logic [0:0]        wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              init_busy
);

  sweep_st_t         st;
  logic [ADDR_W-1:0] cnt;
  logic              rd_vld;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      st        <= CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld <= 1'b1;
      case (st)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            st        <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN:     st <= RUN;
        default: st <= CLEAR;
      endcase
    end
  end

  // The sweep owns the write port; rst_n gating keeps reset from writing.
  always_comb begin
    we    = 1'b0;
    waddr = addra;
    wdata = dina;
    unique case (1'b1)
      (st == CLEAR): begin
        we    = rst_n;
        waddr = cnt;
        wdata = '0;
      end
      default: we = wea[0];
    endcase
  end

  dram_fft_re_core u_core (
    .clk   (clka),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addrb),
    .rdata (rdata)
  );

  // Array output has no reset; mask it until the first post-reset read.
  assign doutb = rd_vld ? rdata : '0;

endmodule

// File: tb/tb_dram_fft_re.sv
// Scoreboard bench for dram_fft_re.
// Directed stimulus; reads are checked one cycle after issue.
module tb_dram_fft_re;

  logic        clka;
  logic        rst_n;
  logic [0:0]  wea;
  logic [7:0]  addra;
  logic [22:0] dina;
  logic [7:0]  addrb;
  logic [22:0] doutb;
  logic        init_busy;

  typedef struct {
    logic [7:0]  a;
    logic [22:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic        rd_req;
  int          n_chk;
  int          n_fail;
  logic [22:0] mdl [256];

  dram_fft_re dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .addrb     (addrb),
    .doutb     (doutb),
    .init_busy (init_busy)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic c;
    exp_t e;
    forever begin
      @(posedge clka);
      c = rd_req;
      @(negedge clka);
      if (c) begin
        if (exp_q.size() == 0) begin
          chk("rd_no_exp", 32'(doutb), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          n_chk++;
          if (doutb !== e.d) begin
            n_fail++;
            $display("FAIL rd[%0h]: got %0h expected %0h", e.a, doutb, e.d);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic wr(logic [7:0] a, logic [22:0] d);
    wea   = 1'b1;
    addra = a;
    dina  = d;
    mdl[a] = d;
    cyc();
    wea = 1'b0;
  endtask

  task automatic rd(logic [7:0] a, logic [22:0] e);
    addrb  = a;
    rd_req = 1'b1;
    exp_q.push_back('{a, e});
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic wait_init(string nm, bit pulse);
    int n;
    n = 0;
    while (init_busy && n < 300) begin
      if (pulse && n == 20) begin
        wea   = 1'b1;
        addra = 8'h05;
        dina  = 23'h123;
      end else begin
        wea = 1'b0;
      end
      @(posedge clka);
      #1;
      n++;
    end
    wea = 1'b0;
    chk(nm, 32'(n), 32'd256);
  endtask

  initial begin
    logic [7:0]  a;
    logic [22:0] m;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    wea    = 1'b0;
    addra  = '0;
    dina   = '0;
    addrb  = '0;
    rd_req = 1'b0;
    fork
      monitor();
    join_none

    #12;
    chk("rst_doutb", 32'(doutb), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    #5 rst_n = 1'b1;
    wait_init("init_len", 1'b0);
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    for (int i = 0; i < 256; i++) rd(8'(i), 23'd0);

    // ramp with a data carry across bit 4
    m = 23'h3FFFF0;
    for (int i = 0; i < 50; i++) wr(8'(20 + i), m + 23'(i));
    for (int i = 0; i < 50; i++) rd(8'(20 + i), m + 23'(i));

    for (int i = 0; i < 50; i++) begin
      wea   = 1'b0;
      addra = i[0] ? 8'h15 : 8'hEA;
      dina  = i[0] ? 23'h7FFFFF : 23'h2AAAAA;
      cyc();
    end
    for (int i = 0; i < 256; i++) rd(8'(i), mdl[i]);

    wr(8'h10, 23'h000AAA);
    wea    = 1'b1;
    addra  = 8'h10;
    dina   = 23'h7FFFFF;
    addrb  = 8'h10;
    rd_req = 1'b1;
    exp_q.push_back('{8'h10, 23'h000AAA});
    mdl[8'h10] = 23'h7FFFFF;
    cyc();
    wea    = 1'b0;
    rd_req = 1'b0;
    rd(8'h10, 23'h7FFFFF);

    a = 8'd250;
    for (int i = 0; i < 10; i++) begin
      wr(a, 23'(i + 1));
      a = a + 8'd1;
    end
    rd(8'd255, 23'd6);
    rd(8'd0, 23'd7);
    a = 8'd250;
    for (int i = 0; i < 10; i++) begin
      rd(a, 23'(i + 1));
      a = a + 8'd1;
    end

    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_doutb", 32'(doutb), 32'd0);
    chk("arst_busy", 32'(init_busy), 32'd1);
    @(posedge clka);
    #3 rst_n = 1'b1;
    wait_init("reinit_len", 1'b1);
    for (int i = 0; i < 256; i++) rd(8'(i), 23'd0);

    cyc();
    cyc();
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
